// File: rtl/tdm_tx_pkg.sv
// tdm_tx_pkg -- shared constants and state encoding for the TDM transmitter.
//   N_CH         channels per frame (the design supports exactly 4)
//   SLOT_BITS    BICK periods per channel slot
//   FRAME_PHASES clk_256fs cycles per frame
//   state_t      IDLE / RUN
package tdm_tx_pkg;

    localparam int N_CH         = 4;
    localparam int SLOT_BITS    = 32;
    localparam int FRAME_PHASES = 256;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_tx_if.sv
// tdm_tx_if -- sample producer <-> TDM transmitter handshake.
//   en            producer requests frames
//   mute          load zeros instead of samples at the latch
//   sample0..3    signed channel samples, stable across the latch cycle
//   sample_latch  transmitter pulse: samples are captured at the end of it
// Modports: master = sample producer, slave = transmitter.
interface tdm_tx_if #(
    parameter int W = 16
);

    logic         en;
    logic         mute;
    logic [W-1:0] sample0;
    logic [W-1:0] sample1;
    logic [W-1:0] sample2;
    logic [W-1:0] sample3;
    logic         sample_latch;

    modport master (
        output en, mute, sample0, sample1, sample2, sample3,
        input  sample_latch
    );

    modport slave (
        input  en, mute, sample0, sample1, sample2, sample3,
        output sample_latch
    );

endinterface

// File: rtl/tdm_tx.sv
// tdm_tx -- 4-channel TDM serializer, I2S-style (data delayed one BICK).
// Ports:
//   clk_256fs  sole clock, 256 x fs
//   rst        synchronous active-high reset
//   src        tdm_tx_if.slave: en, mute, sample0..3 in; sample_latch out
//   bick       bit clock = phase[0]
//   lrck       frame sync, high for the first 32 BICKs of a frame
//   sdout      serial data, MSB first, slot = 32 BICKs, W data bits
//   phase      frame phase 0..255
//   running    high while in RUN
// bick/lrck/sdout/phase are all registered from the same next-phase value,
// so they stay aligned within a cycle.
module tdm_tx #(
    parameter int W    = 16,
    parameter int N_CH = 4
) (
    input  logic        clk_256fs,
    input  logic        rst,
    tdm_tx_if.slave     src,
    output logic        bick,
    output logic        lrck,
    output logic        sdout,
    output logic [7:0]  phase,
    output logic        running
);

    import tdm_tx_pkg::*;

    state_t                   state;
    logic [N_CH-1:0][W-1:0]   shadow;

    logic                     last_phase;
    logic                     latch;
    logic                     run_nxt;
    logic [7:0]               phase_nxt;
    logic [6:0]               b_nxt;
    logic [6:0]               p_nxt;
    logic [1:0]               slot;
    logic [4:0]               bit_idx;
    logic [W-1:0]             shifted;
    logic                     bick_nxt;
    logic                     lrck_nxt;
    logic                     sdout_nxt;

    assign last_phase = (phase == 8'(FRAME_PHASES - 1));

    // Latch request: any en cycle while idle, or the frame's last cycle in RUN.
    always_comb begin
        latch = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    latch = src.en;
                RUN:     latch = src.en && last_phase;
                default: latch = 1'b0;
            endcase
        end
    end

    assign src.sample_latch = latch;
    assign running          = (state == RUN);

    // Next-cycle frame position; outputs are precomputed from it so they are
    // registered yet aligned with the phase register.
    always_comb begin
        run_nxt   = (state == RUN) ? (!last_phase || latch) : latch;
        phase_nxt = (state == RUN) ? phase + 8'd1 : 8'd0;
        b_nxt     = phase_nxt[7:1];
        p_nxt     = b_nxt - 7'd1;          // one-BICK delay, wraps 0 -> 127
        slot      = p_nxt[6:5];
        bit_idx   = p_nxt[4:0];
        // Shifting the bit of interest into the MSB makes bit_idx >= W fall
        // off the end, which yields the zero slot padding for free.
        shifted   = shadow[slot] << bit_idx;
        bick_nxt  = run_nxt && phase_nxt[0];
        lrck_nxt  = run_nxt && (b_nxt < 7'(SLOT_BITS));
        sdout_nxt = run_nxt && (b_nxt != 7'd0) && shifted[W-1];
    end

    always_ff @(posedge clk_256fs) begin
        if (rst) begin
            state  <= IDLE;
            phase  <= 8'd0;
            bick   <= 1'b0;
            lrck   <= 1'b0;
            sdout  <= 1'b0;
            shadow <= '0;
        end else begin
            state <= run_nxt ? RUN : IDLE;
            phase <= run_nxt ? phase_nxt : 8'd0;
            bick  <= bick_nxt;
            lrck  <= lrck_nxt;
            sdout <= sdout_nxt;
            if (latch) begin
                shadow <= src.mute ? '0
                        : {src.sample3, src.sample2, src.sample1, src.sample0};
            end
        end
    end

endmodule

// File: doc/tdm_tx.md
TDM_TX -- requirements
Module: tdm_tx

Interface
REQ-001 Parameter W, default 16, sample width in bits per channel.
REQ-002 Parameter N_CH, default 4, channels per frame; fixed at 4, other values are unsupported.
REQ-003 clk_256fs  input  1  sole clock, 256 x fs; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  request to run frames; sampled only as defined in Function.
REQ-006 mute  input  1  when high at a latch, zeros are loaded in place of samples.
REQ-007 sample0..sample3  input  W each  signed channel samples, held stable by the producer across the latch cycle.
REQ-008 sample_latch  output  1  one-cycle pulse; inputs are captured at the end of this cycle.
REQ-009 bick  output  1  bit clock, clk_256fs/2.
REQ-010 lrck  output  1  frame sync.
REQ-011 sdout  output  1  serial data.
REQ-012 phase  output  8  current frame phase, 0..255.
REQ-013 running  output  1  high while in RUN.

Function
REQ-014 State machine SHALL have two states, IDLE and RUN; reset enters IDLE.
REQ-015 IDLE: phase, bick, lrck and sdout SHALL be held at 0, and sample_latch SHALL pulse in any cycle where en=1.
REQ-016 IDLE->RUN SHALL occur on the edge that ends a sample_latch cycle; the first RUN cycle SHALL have phase=0.
REQ-017 RUN: phase SHALL increment by 1 per cycle, wrapping 255->0.
REQ-018 RUN: sample_latch SHALL be high exactly when phase=255 and en=1.
REQ-019 RUN->IDLE SHALL occur only at the phase=255 edge with en=0; en deasserted mid-frame SHALL complete the current frame.
REQ-020 Shadow registers SHALL load sample0..3 (or zeros if mute=1) on the edge ending a sample_latch cycle; the inputs SHALL have no other effect.
REQ-021 bick SHALL equal phase[0], so it is 0 on even phases and 1 on odd phases.
REQ-022 Bit index b = phase[7:1] (0..127).
REQ-023 lrck SHALL be 1 for b in 0..31 and 0 otherwise while RUN.
REQ-024 Data SHALL be I2S-delayed by one BICK: p = (b-1) mod 128, slot = p[6:5], bit = p[4:0].
REQ-025 sdout SHALL be shadow[slot][W-1-bit] for bit < W, and 0 for bit >= W and for b=0.
REQ-026 sdout SHALL change only on even phases (the bick falling edge).
REQ-027 bick, lrck, sdout and phase SHALL be registered outputs, mutually aligned in the same cycle, with no combinational path from inputs.
REQ-028 Simultaneous mute=1 and latch SHALL load zeros for all four slots; mute elsewhere SHALL have no effect.

Reset
REQ-029 rst=1 SHALL force IDLE and clear phase, bick, lrck, sdout, sample_latch, running and all shadow registers to 0 in the next cycle.
REQ-030 rst mid-frame SHALL abort the frame immediately, with no completion.
REQ-031 After rst release, sample_latch SHALL pulse in the first cycle with en=1.

Structure
REQ-032 A shared package SHALL hold the constants N_CH=4, SLOT_BITS=32, FRAME_PHASES=256 and the state enum {IDLE, RUN}.
REQ-033 The block SHALL be a single module with no sub-module; slot and bit selection SHALL be inline.

Verification
REQ-034 Scenario 1: en=1 with samples 16'h8001, 16'h7FFE, 16'h0F0F, 16'hF0F0.
- Required: in the second frame the slot-0 bits on b=1..16 read 1000000000000001.
- Required: b=17..32 read 0 (slot padding).
- Required: slot 3 MSB appears at b=97.
REQ-035 Scenario 2: frame timing.
- Required: lrck rises at phase 0 and falls at phase 64.
- Required: bick toggles every cycle.
- Required: sample_latch is high only at phase 255.
REQ-036 Scenario 3: en dropped at phase 100.
- Required: the frame runs to phase 255, then IDLE with all outputs 0.
- Required: no further sample_latch while en=0.
REQ-037 Scenario 4: mute=1 at the latch with samples 16'hFFFF.
- Required: sdout stays 0 for the whole next frame.
REQ-038 Scenario 5: rst pulsed at phase 130.
- Required: the next cycle has phase=0, lrck=0, sdout=0, running=0.
- Required: re-enabling yields the first slot-0 MSB on b=1 of the first frame and carries the latched data.
REQ-039 Scenario 6: samples changed on every non-latch cycle.
- Required: the serialized data equals only the values present at the phase-255 latch.
